// File: rtl/mac_accumulator.sv
// Accumulate stage after the 16x16 multiplier: sums a programmed number of
// unsigned products under valid/ready and hands the result on under valid/ready.
module mac_accumulator #(
    parameter int unsigned PROD_W   = 32,
    parameter int unsigned ACC_W    = 40,
    parameter int unsigned CNT_W    = 8,
    parameter bit          SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               prod_ready_q, prod_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               xfer_c;
    logic [SUM_W-1:0]   sum_c;

    assign xfer_c = prod_valid & prod_ready_q;
    // One extra bit so the carry-out is the overflow indication.
    assign sum_c  = {1'b0, acc_q} + SUM_W'(prod);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    len_d   = len;
                    state_d = (len != '0) ? S_ACCUM : S_DONE;
                end
            end
            S_ACCUM: begin
                if (xfer_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sum_c[ACC_W]) begin
                        ovf_d = 1'b1;
                    end
                    // Once clamped, the sum stays pinned at all-ones for the run.
                    if (SATURATE && (sum_c[ACC_W] || ovf_q)) begin
                        acc_d = {ACC_W{1'b1}};
                    end else begin
                        acc_d = sum_c[ACC_W-1:0];
                    end
                    if (cnt_d == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        prod_ready_d = (state_d == S_ACCUM);
        out_valid_d  = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= prod_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign acc_out    = acc_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a 40-bit wrapping instance plus 32-bit
// wrapping and saturating instances sharing one stimulus stream.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        prod_valid;
    logic [31:0] prod;
    logic        out_ready;

    logic        m_pr, m_ov, m_busy, m_ovf;
    logic [39:0] m_acc;
    logic        w_pr, w_ov, w_busy, w_ovf;
    logic [31:0] w_acc;
    logic        s_pr, s_ov, s_busy, s_ovf;
    logic [31:0] s_acc;

    typedef struct {
        logic [39:0] a40;
        logic        o40;
        logic [31:0] aw;
        logic        ow;
        logic [31:0] as;
        logic        os;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   xfers = 0;

    always #5 clk = ~clk;

    mac_accumulator u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod_valid(prod_valid),
        .prod(prod), .prod_ready(m_pr), .acc_out(m_acc), .out_valid(m_ov),
        .out_ready(out_ready), .busy(m_busy), .overflow(m_ovf)
    );

    mac_accumulator #(.ACC_W(32), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod_valid(prod_valid),
        .prod(prod), .prod_ready(w_pr), .acc_out(w_acc), .out_valid(w_ov),
        .out_ready(out_ready), .busy(w_busy), .overflow(w_ovf)
    );

    mac_accumulator #(.ACC_W(32), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod_valid(prod_valid),
        .prod(prod), .prod_ready(s_pr), .acc_out(s_acc), .out_valid(s_ov),
        .out_ready(out_ready), .busy(s_busy), .overflow(s_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [39:0] a40, input logic o40,
                                 input logic [31:0] aw, input logic ow,
                                 input logic [31:0] as, input logic os);
        exp_t e;
        e.a40 = a40; e.o40 = o40; e.aw = aw; e.ow = ow; e.as = as; e.os = os;
        exp_q.push_back(e);
    endfunction

    // Monitor: counts product transfers and scores every result handoff.
    always @(negedge clk) begin
        if (!rst) begin
            if (prod_valid && m_pr) xfers++;
            if (m_ov && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 64'(m_acc), 64'h0);
                    chk("unexpected_result_flag", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("acc40", 64'(m_acc), 64'(e.a40));
                    chk("ovf40", 64'(m_ovf), 64'(e.o40));
                    chk("acc32_wrap", 64'(w_acc), 64'(e.aw));
                    chk("ovf32_wrap", 64'(w_ovf), 64'(e.ow));
                    chk("valid32_wrap", 64'(w_ov), 64'(1));
                    chk("acc32_sat", 64'(s_acc), 64'(e.as));
                    chk("ovf32_sat", 64'(s_ovf), 64'(e.os));
                    chk("valid32_sat", 64'(s_ov), 64'(1));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        cyc();
        start = 1'b0;
    endtask

    // Present p after 'gaps' idle cycles and hold it until it is accepted.
    task automatic send(input logic [31:0] p, input int gaps);
        logic took;
        prod_valid = 1'b0;
        for (int g = 0; g < gaps; g++) cyc();
        prod_valid = 1'b1;
        prod       = p;
        took       = 1'b0;
        for (int k = 0; k < 20 && !took; k++) begin
            @(negedge clk);
            took = m_pr;
            cyc();
        end
        if (!took) chk("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic handoff(input logic [39:0] keep);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("idle_valid", 64'(m_ov), 64'(0));
        chk("idle_busy", 64'(m_busy), 64'(0));
        chk("idle_acc_kept", 64'(m_acc), 64'(keep));
    endtask

    initial begin
        int x0;
        rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0; out_ready = 1'b0;
        #3;
        chk("rst_acc", 64'(m_acc), 64'(0));
        chk("rst_valid", 64'(m_ov), 64'(0));
        chk("rst_ready", 64'(m_pr), 64'(0));
        chk("rst_busy", 64'(m_busy), 64'(0));
        chk("rst_ovf", 64'(m_ovf), 64'(0));
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // 1: back-to-back products; result and valid together on last transfer
        push(40'h00FFFEDB1A, 1'b0, 32'hFFFEDB1A, 1'b0, 32'hFFFEDB1A, 1'b0);
        start_run(8'd3);
        chk("t1_busy", 64'(m_busy), 64'(1));
        chk("t1_ready", 64'(m_pr), 64'(1));
        send(32'd56088, 0);
        chk("t1_latency_acc", 64'(m_acc), 64'(56088));
        send(32'd1, 0);
        send(32'hFFFE0001, 0);
        prod_valid = 1'b0;
        chk("t1_valid_on_last", 64'(m_ov), 64'(1));
        chk("t1_acc_on_last", 64'(m_acc), 64'h00FFFEDB1A);
        chk("t1_ready_low", 64'(m_pr), 64'(0));
        handoff(40'h00FFFEDB1A);

        // 2: gapped valid pattern 1,0,1,0,0,1,1; extra valid after last must not be taken
        push(40'd34, 1'b0, 32'd34, 1'b0, 32'd34, 1'b0);
        x0 = xfers;
        start_run(8'd4);
        send(32'd7, 0);
        send(32'd8, 1);
        send(32'd9, 2);
        send(32'd10, 0);
        prod = 32'd999;
        chk("t2_ready_low", 64'(m_pr), 64'(0));
        cyc(); cyc();
        prod_valid = 1'b0;
        chk("t2_xfers", 64'(xfers - x0), 64'(4));
        chk("t2_acc_hold", 64'(m_acc), 64'(34));
        handoff(40'd34);

        // 3: carry out of 32 bits: wrap vs clamp vs no overflow at 40 bits
        push(40'h01FFFC0002, 1'b0, 32'hFFFC0002, 1'b1, 32'hFFFFFFFF, 1'b1);
        start_run(8'd2);
        send(32'hFFFE0001, 0);
        send(32'hFFFE0001, 0);
        prod_valid = 1'b0;
        handoff(40'h01FFFC0002);

        // 3b: saturated sum stays clamped after further products
        push(40'h01FFFC0007, 1'b0, 32'hFFFC0007, 1'b1, 32'hFFFFFFFF, 1'b1);
        start_run(8'd3);
        send(32'hFFFE0001, 0);
        send(32'hFFFE0001, 0);
        send(32'd5, 0);
        prod_valid = 1'b0;
        handoff(40'h01FFFC0007);

        // 4: len=0 goes straight to DONE with zero and consumes nothing
        push(40'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        x0 = xfers;
        prod_valid = 1'b1;
        prod = 32'd77;
        start_run(8'd0);
        chk("t4_valid", 64'(m_ov), 64'(1));
        chk("t4_acc", 64'(m_acc), 64'(0));
        chk("t4_busy", 64'(m_busy), 64'(1));
        cyc();
        prod_valid = 1'b0;
        chk("t4_no_xfer", 64'(xfers - x0), 64'(0));
        handoff(40'd0);

        // 5: DONE stalled 5 cycles with start pulses ignored
        push(40'd300, 1'b0, 32'd300, 1'b0, 32'd300, 1'b0);
        start_run(8'd2);
        send(32'd100, 0);
        send(32'd200, 0);
        prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = 8'd5;
            cyc();
            start = 1'b0;
            chk("t5_valid_hold", 64'(m_ov), 64'(1));
            chk("t5_acc_hold", 64'(m_acc), 64'(300));
            chk("t5_ovf_hold", 64'(m_ovf), 64'(0));
        end
        handoff(40'd300);

        // 6: async reset mid-run, then a fresh single-term run
        start_run(8'd4);
        send(32'd1, 0);
        send(32'd2, 0);
        prod_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_acc", 64'(m_acc), 64'(0));
        chk("t6_rst_ready", 64'(m_pr), 64'(0));
        chk("t6_rst_busy", 64'(m_busy), 64'(0));
        chk("t6_rst_valid", 64'(m_ov), 64'(0));
        cyc();
        rst = 1'b0;
        cyc();
        push(40'd5, 1'b0, 32'd5, 1'b0, 32'd5, 1'b0);
        start_run(8'd1);
        send(32'd5, 0);
        prod_valid = 1'b0;
        chk("t6_acc", 64'(m_acc), 64'(5));
        handoff(40'd5);

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) cyc();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
